// File: rtl/dma_priority_arbiter.sv
// Bus-request arbiter for the 8237A DMA channels: runs the HRQ/HLDA handshake with the CPU and
// holds one channel's Dack, chosen by fixed or rotating priority, until service completes.
module dma_priority_arbiter #(
  parameter int unsigned NumCh = 4,
  parameter int unsigned ChW   = $clog2(NumCh)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumCh-1:0] dreq_i,
  input  logic             dreq_low_i,
  input  logic             dack_high_i,
  input  logic             rotate_pri_i,
  input  logic [NumCh-1:0] mask_i,
  input  logic             hlda_i,
  input  logic             xfer_done_i,
  output logic             hrq_o,
  output logic [NumCh-1:0] dack_o,
  output logic [ChW-1:0]   grant_o,
  output logic             grant_valid_o
);

  typedef enum logic [1:0] {StIdle, StReq, StGrant, StRelease} state_e;

  state_e             state_q, state_d;
  logic [NumCh-1:0]   req_q, req_d;
  logic [NumCh-1:0]   onehot_q, onehot_d;
  logic [ChW-1:0]     grant_q, grant_d;
  logic [ChW-1:0]     ptr_q, ptr_d;
  logic               hrq_q, hrq_d;
  logic               gv_q, gv_d;

  logic               win_found;
  logic [ChW-1:0]     win_idx;
  logic [ChW-1:0]     base;
  logic [ChW-1:0]     cand;
  logic [NumCh-1:0]   win_oh;

  assign req_d = (dreq_low_i ? ~dreq_i : dreq_i) & ~mask_i;

  // Search wraps naturally in ChW bits because NumCh is a power of two.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    base      = rotate_pri_i ? ptr_q : '0;
    for (int unsigned i = 0; i < NumCh; i++) begin
      cand = base + ChW'(i);
      if (!win_found && req_q[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign win_oh = {{(NumCh-1){1'b0}}, 1'b1} << win_idx;

  always_comb begin
    state_d  = state_q;
    hrq_d    = hrq_q;
    onehot_d = onehot_q;
    grant_d  = grant_q;
    gv_d     = gv_q;
    ptr_d    = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req_q) begin
          state_d = StReq;
          hrq_d   = 1'b1;
        end
      end
      StReq: begin
        if (hlda_i) begin
          if (win_found) begin
            state_d  = StGrant;
            onehot_d = win_oh;
            grant_d  = win_idx;
            gv_d     = 1'b1;
          end else begin
            state_d = StRelease;
            hrq_d   = 1'b0;
          end
        end
      end
      StGrant: begin
        // Completion wins over a simultaneous Hlda drop.
        if (xfer_done_i) begin
          state_d  = StRelease;
          hrq_d    = 1'b0;
          onehot_d = '0;
          gv_d     = 1'b0;
          if (rotate_pri_i) begin
            ptr_d = grant_q + ChW'(1);
          end
        end else if (!hlda_i) begin
          state_d  = StIdle;
          hrq_d    = 1'b0;
          onehot_d = '0;
          gv_d     = 1'b0;
        end
      end
      StRelease: begin
        hrq_d = 1'b0;
        if (!hlda_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d  = StIdle;
        hrq_d    = 1'b0;
        onehot_d = '0;
        gv_d     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      req_q    <= '0;
      hrq_q    <= 1'b0;
      onehot_q <= '0;
      grant_q  <= '0;
      gv_q     <= 1'b0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      hrq_q    <= hrq_d;
      onehot_q <= onehot_d;
      grant_q  <= grant_d;
      gv_q     <= gv_d;
      ptr_q    <= ptr_d;
    end
  end

  assign hrq_o         = hrq_q;
  assign dack_o        = dack_high_i ? onehot_q : ~onehot_q;
  assign grant_o       = grant_q;
  assign grant_valid_o = gv_q;

`ifndef SYNTHESIS
  a_onehot_dack: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(onehot_q));
  a_gv_matches:  assert property (@(posedge clk_i) disable iff (rst_i) gv_q == (|onehot_q));
`endif

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Randomized bench for dma_priority_arbiter: a driver plays CPU and timing FSM, a monitor
// scores each grant against a queue filled from a priority reference model.
module tb_dma_priority_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [3:0] dreq_i;
  logic       dreq_low_i;
  logic       dack_high_i;
  logic       rotate_pri_i;
  logic [3:0] mask_i;
  logic       hlda_i;
  logic       xfer_done_i;
  logic       hrq_o;
  logic [3:0] dack_o;
  logic [1:0] grant_o;
  logic       grant_valid_o;

  dma_priority_arbiter #(.NumCh(4), .ChW(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .dreq_i       (dreq_i),
    .dreq_low_i   (dreq_low_i),
    .dack_high_i  (dack_high_i),
    .rotate_pri_i (rotate_pri_i),
    .mask_i       (mask_i),
    .hlda_i       (hlda_i),
    .xfer_done_i  (xfer_done_i),
    .hrq_o        (hrq_o),
    .dack_o       (dack_o),
    .grant_o      (grant_o),
    .grant_valid_o(grant_valid_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0] grant;
    logic [3:0] dack;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ptr_m  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Reference priority: first requesting channel found walking up from start, modulo 4.
  function automatic int ref_winner(input logic [3:0] act, input int start);
    for (int k = 0; k < 4; k++) begin
      if (act[(start + k) % 4]) return (start + k) % 4;
    end
    return -1;
  endfunction

  // Monitor: pops an expectation when a grant appears, then checks Dack stays put.
  initial begin
    logic [3:0] held;
    logic       gv_prev;
    exp_t       e;
    held    = '0;
    gv_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (grant_valid_o && !gv_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant_valid_o), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("grant_idx", 32'(grant_o), 32'(e.grant));
          chk("grant_dack", 32'(dack_o), 32'(e.dack));
          held = e.dack;
        end
      end else if (grant_valid_o) begin
        chk("dack_held", 32'(dack_o), 32'(held));
      end
      gv_prev = grant_valid_o;
    end
  end

  // kind: 0 xfer done, 1 cpu abort, 2 reset mid-grant, 3 xfer done with hlda drop
  task automatic session(input logic [3:0] dreq, input logic [3:0] mask, input logic dl,
                         input logic dh, input logic rot, input int kind);
    logic [3:0] act;
    logic [3:0] oh;
    logic [3:0] dinact;
    exp_t       e;
    int         w;
    act    = (dl ? ~dreq : dreq) & ~mask;
    dinact = dh ? 4'b0000 : 4'b1111;
    dreq_i = dreq; mask_i = mask; dreq_low_i = dl; dack_high_i = dh; rotate_pri_i = rot;
    tick();
    chk("hrq_early", 32'(hrq_o), 32'd0);
    tick();
    if (act == 4'b0) begin
      chk("hrq_noreq", 32'(hrq_o), 32'd0);
      tick();
      chk("hrq_noreq2", 32'(hrq_o), 32'd0);
      mask_i = 4'hF;
      tick();
      return;
    end
    chk("hrq_rise", 32'(hrq_o), 32'd1);
    repeat ($urandom_range(0, 2)) begin
      tick();
      chk("hrq_wait", 32'(hrq_o), 32'd1);
      chk("gv_wait", 32'(grant_valid_o), 32'd0);
    end
    w       = ref_winner(act, rot ? ptr_m : 0);
    oh      = 4'b0001 << w;
    e.grant = 2'(w);
    e.dack  = dh ? oh : ~oh;
    exp_q.push_back(e);
    hlda_i = 1'b1;
    tick();
    chk("gv_rise", 32'(grant_valid_o), 32'd1);
    repeat ($urandom_range(1, 3)) begin
      dreq_i = 4'($urandom);
      mask_i = 4'($urandom);
      tick();
      chk("hrq_grant", 32'(hrq_o), 32'd1);
      chk("gv_grant", 32'(grant_valid_o), 32'd1);
    end
    if (kind == 0 || kind == 3) begin
      xfer_done_i = 1'b1;
      if (kind == 3) hlda_i = 1'b0;
      tick();
      xfer_done_i = 1'b0;
      mask_i      = 4'hF;
      chk("hrq_done", 32'(hrq_o), 32'd0);
      chk("gv_done", 32'(grant_valid_o), 32'd0);
      chk("dack_done", 32'(dack_o), 32'(dinact));
      chk("grant_kept", 32'(grant_o), 32'(w));
      if (rot) ptr_m = (w + 1) % 4;
      if (kind == 0) begin
        repeat ($urandom_range(0, 2)) begin
          tick();
          chk("hrq_release", 32'(hrq_o), 32'd0);
        end
        hlda_i = 1'b0;
      end
      tick();
      chk("hrq_release2", 32'(hrq_o), 32'd0);
      tick();
    end else if (kind == 1) begin
      hlda_i = 1'b0;
      mask_i = 4'hF;
      tick();
      chk("hrq_abort", 32'(hrq_o), 32'd0);
      chk("gv_abort", 32'(grant_valid_o), 32'd0);
      chk("dack_abort", 32'(dack_o), 32'(dinact));
      tick();
    end else begin
      rst_i  = 1'b1;
      hlda_i = 1'b0;
      mask_i = 4'hF;
      tick();
      rst_i = 1'b0;
      chk("hrq_rst", 32'(hrq_o), 32'd0);
      chk("gv_rst", 32'(grant_valid_o), 32'd0);
      chk("grant_rst", 32'(grant_o), 32'd0);
      chk("dack_rst", 32'(dack_o), 32'(dinact));
      ptr_m = 0;
      tick();
    end
  endtask

  task automatic withdraw();
    dreq_i = 4'b0010; mask_i = 4'b0000; dreq_low_i = 1'b0; dack_high_i = 1'b1;
    tick();
    tick();
    chk("wd_hrq_rise", 32'(hrq_o), 32'd1);
    dreq_i = 4'b0000;
    tick();
    chk("wd_hrq_hold", 32'(hrq_o), 32'd1);
    hlda_i = 1'b1;
    tick();
    chk("wd_hrq_fall", 32'(hrq_o), 32'd0);
    chk("wd_gv", 32'(grant_valid_o), 32'd0);
    chk("wd_dack", 32'(dack_o), 32'd0);
    hlda_i = 1'b0;
    mask_i = 4'hF;
    tick();
    chk("wd_hrq_idle", 32'(hrq_o), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int kind;
    rst_i = 1'b1; dreq_i = '0; dreq_low_i = 1'b0; dack_high_i = 1'b1; rotate_pri_i = 1'b0;
    mask_i = 4'hF; hlda_i = 1'b0; xfer_done_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_hrq", 32'(hrq_o), 32'd0);
    chk("rst_gv", 32'(grant_valid_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_dack_hi", 32'(dack_o), 32'h0);
    dack_high_i = 1'b0;
    #1;
    chk("rst_dack_lo", 32'(dack_o), 32'hF);
    tick();

    session(4'b0100, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    session(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    session(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    session(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, 0);
    session(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, 0);
    session(4'b1010, 4'b0000, 1'b0, 1'b1, 1'b1, 0);
    session(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 0);
    session(4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 0);
    withdraw();
    session(4'b1110, 4'b0000, 1'b1, 1'b0, 1'b1, 1);
    session(4'b0110, 4'b0000, 1'b0, 1'b1, 1'b1, 0);
    session(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 2);
    session(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 0);
    session(4'b1000, 4'b0000, 1'b0, 1'b1, 1'b1, 3);
    session(4'b1111, 4'b0000, 1'b0, 1'b1, 1'b1, 0);

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r == 6) ? 3 : (r < 9) ? 1 : 2;
      session(4'($urandom), 4'($urandom) & 4'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), kind);
    end

    tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
